// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: grants one of two requesters (A = core LSU, B = DMA) access to a single-port
// data memory and sequences each transaction IDLE -> ISSUE -> RESP. Optional macro: DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [1:0]  a_byte_sel_i,
    input  logic        a_sign_i,
    input  logic [13:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,

    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [1:0]  b_byte_sel_i,
    input  logic        b_sign_i,
    input  logic [13:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_gnt_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,

    output logic        dmem_rden_o,
    output logic        dmem_wen_o,
    output logic [1:0]  dmem_byte_sel_o,
    output logic        dmem_sign_o,
    output logic [13:0] dmem_addr_o,
    output logic [31:0] dmem_data_in_o,
    input  logic [31:0] dmem_data_out_i
);

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  starve_q;
    logic        owner_b_q;
    logic        fail_q;
    logic        we_q;
    logic        sign_q;
    logic [1:0]  sel_q;
    logic [13:0] addr_q;
    logic [31:0] wdata_q;
    logic        rden_q;
    logic        wen_q;
    logic        a_rvalid_q;
    logic        b_rvalid_q;
    logic        a_err_q;
    logic        b_err_q;
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    logic        w_idle;
    logic        w_gnt_a;
    logic        w_gnt_b;
    logic        w_we;
    logic        w_sign;
    logic [1:0]  w_sel;
    logic [13:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic        w_resp_rd;

    // Grants are combinational and gated by reset so nothing leaks out while rst_n is low.
    assign w_idle  = rst_n && (state_q == IDLE);
    assign w_gnt_b = w_idle && b_req_i && (!a_req_i || (starve_q == C_LIMIT));
    assign w_gnt_a = w_idle && a_req_i && !w_gnt_b;

    assign w_we    = w_gnt_b ? b_we_i       : a_we_i;
    assign w_sign  = w_gnt_b ? b_sign_i     : a_sign_i;
    assign w_sel   = w_gnt_b ? b_byte_sel_i : a_byte_sel_i;
    assign w_addr  = w_gnt_b ? b_addr_i     : a_addr_i;
    assign w_wdata = w_gnt_b ? b_wdata_i    : a_wdata_i;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign w_misalign = (w_sel == 2'b11)
                     || ((w_sel == 2'b10) && (w_addr[1:0] != 2'b00))
                     || ((w_sel == 2'b01) && w_addr[0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Read data is only live on DMEM during RESP; pass it through then and keep a copy.
    assign w_resp_rd = (state_q == RESP) && !we_q && !fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            owner_b_q  <= 1'b0;
            fail_q     <= 1'b0;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            sel_q      <= 2'b00;
            addr_q     <= 14'd0;
            wdata_q    <= 32'd0;
            rden_q     <= 1'b0;
            wen_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= 32'd0;
            b_rdata_q  <= 32'd0;
        end else begin
            rden_q     <= 1'b0;
            wen_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_gnt_a || w_gnt_b) begin
                        owner_b_q <= w_gnt_b;
                        fail_q    <= w_misalign;
                        we_q      <= w_we;
                        sign_q    <= w_sign;
                        sel_q     <= w_sel;
                        addr_q    <= w_addr;
                        wdata_q   <= w_wdata;
                        if (w_gnt_b) begin
                            starve_q <= 4'd0;
                        end else if (b_req_i && (starve_q != C_LIMIT)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                        if (w_misalign) begin
                            state_q    <= RESP;
                            a_rvalid_q <= w_gnt_a;
                            b_rvalid_q <= w_gnt_b;
                            a_err_q    <= w_gnt_a;
                            b_err_q    <= w_gnt_b;
                        end else begin
                            state_q <= ISSUE;
                            rden_q  <= !w_we;
                            wen_q   <= w_we;
                        end
                    end
                end
                ISSUE: begin
                    state_q    <= RESP;
                    a_rvalid_q <= !owner_b_q;
                    b_rvalid_q <= owner_b_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    if (w_resp_rd && !owner_b_q) begin
                        a_rdata_q <= dmem_data_out_i;
                    end
                    if (w_resp_rd && owner_b_q) begin
                        b_rdata_q <= dmem_data_out_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_gnt_o         = w_gnt_a;
    assign b_gnt_o         = w_gnt_b;
    assign a_rvalid_o      = a_rvalid_q;
    assign b_rvalid_o      = b_rvalid_q;
    assign a_err_o         = a_err_q;
    assign b_err_o         = b_err_q;
    assign a_rdata_o       = (w_resp_rd && !owner_b_q) ? dmem_data_out_i : a_rdata_q;
    assign b_rdata_o       = (w_resp_rd &&  owner_b_q) ? dmem_data_out_i : b_rdata_q;
    assign dmem_rden_o     = rden_q;
    assign dmem_wen_o      = wen_q;
    assign dmem_byte_sel_o = sel_q;
    assign dmem_sign_o     = sign_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_data_in_o  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_dmem_arbiter: transaction-level model plus a DMEM memory model; outputs compared every cycle.
module tb_dmem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req, a_we, a_sign, b_req, b_we, b_sign;
    logic [1:0]  a_sel, b_sel;
    logic [13:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        dmem_rden, dmem_wen, dmem_sign;
    logic [1:0]  dmem_sel;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_byte_sel_i(a_sel), .a_sign_i(a_sign),
        .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
        .a_rdata_o(a_rdata), .a_err_o(a_err),
        .b_req_i(b_req), .b_we_i(b_we), .b_byte_sel_i(b_sel), .b_sign_i(b_sign),
        .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
        .b_rdata_o(b_rdata), .b_err_o(b_err),
        .dmem_rden_o(dmem_rden), .dmem_wen_o(dmem_wen), .dmem_byte_sel_o(dmem_sel),
        .dmem_sign_o(dmem_sign), .dmem_addr_o(dmem_addr), .dmem_data_in_o(dmem_din),
        .dmem_data_out_i(dmem_dout)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  sel;
        logic        sign;
        logic [13:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        va, vb, err, rd;
        logic [31:0] data;
        logic        stb, we;
        logic [13:0] addr;
        logic [1:0]  sel;
        logic        sign;
        logic [31:0] wdata;
    } slot_t;

    cmd_t qa[$];
    cmd_t qb[$];
    int   glog_cyc[$];
    bit   glog_side[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(bit we, logic [1:0] sel, bit sign, logic [13:0] addr, logic [31:0] wd);
        cmd_t c;
        c.we = we; c.sel = sel; c.sign = sign; c.addr = addr; c.wdata = wd;
        return c;
    endfunction

    // Memory semantics: byte lane addr[1:0], half lane addr[1], word ignores low bits.
    function automatic logic [31:0] fmt(logic [31:0] w, logic [13:0] ad, logic [1:0] sel, logic sg);
        logic [7:0]  by;
        logic [15:0] hf;
        by = 8'(w >> (8 * int'(ad[1:0])));
        hf = 16'(w >> (16 * int'(ad[1])));
        case (sel)
            2'b00:   return {{24{sg & by[7]}}, by};
            2'b01:   return {{16{sg & hf[15]}}, hf};
            default: return w;
        endcase
    endfunction

    logic [31:0] dmem_mem [4096];
    logic [31:0] shadow   [4096];

    initial begin
        for (int i = 0; i < 4096; i++) dmem_mem[i] <= 32'd0;
    end

    always @(posedge clk) begin
        if (dmem_rden) dmem_dout <= fmt(dmem_mem[dmem_addr[13:2]], dmem_addr, dmem_sel, dmem_sign);
        if (dmem_wen) begin
            case (dmem_sel)
                2'b00:   dmem_mem[dmem_addr[13:2]][8*dmem_addr[1:0] +: 8]  <= dmem_din[7:0];
                2'b01:   dmem_mem[dmem_addr[13:2]][16*dmem_addr[1] +: 16]  <= dmem_din[15:0];
                default: dmem_mem[dmem_addr[13:2]]                         <= dmem_din;
            endcase
        end
    end

    function automatic void shadow_wr(logic [13:0] ad, logic [1:0] sel, logic [31:0] wd);
        int idx;
        idx = int'(ad[13:2]);
        case (sel)
            2'b00:   shadow[idx][8*int'(ad[1:0]) +: 8] = wd[7:0];
            2'b01:   shadow[idx][16*int'(ad[1]) +: 16] = wd[15:0];
            default: shadow[idx] = wd;
        endcase
    endfunction

    function automatic bit misal(cmd_t c);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        return (c.sel == 2'b11) || (c.sel == 2'b10 && c.addr[1:0] != 2'b00) || (c.sel == 2'b01 && c.addr[0]);
`else
        return (c.sel == 2'b11) && 1'b0;
`endif
    endfunction

    // Model state: expectations for the current and next two cycles, cycles until the next grant may occur.
    slot_t       pipe0, pipe1, pipe2;
    int          cool, starve, cyc;
    logic [31:0] hold_a, hold_b;
    int          wen_cyc;
    logic [1:0]  wen_sel;
    bit          saw_rd1, saw_aerr;

    task automatic model_reset();
        pipe0 = '0; pipe1 = '0; pipe2 = '0;
        cool = 0; starve = 0; hold_a = 32'd0; hold_b = 32'd0;
    endtask

    initial begin
        model_reset();
        cyc = 0; wen_cyc = -1; wen_sel = 2'b00; saw_rd1 = 0; saw_aerr = 0;
    end

    always @(negedge clk) begin : p_cmp
        slot_t e;
        logic  ega, egb;
        cmd_t  c;
        if (rst_n) begin
            cyc++;
            e = pipe0;
            if (e.rd && e.va) hold_a = e.data;
            if (e.rd && e.vb) hold_b = e.data;
            ega = 1'b0; egb = 1'b0;
            if (cool == 0 && (a_req || b_req)) begin
                if (b_req && (!a_req || starve == LIMIT)) egb = 1'b1; else ega = 1'b1;
            end
            chk("a_gnt", a_gnt, ega);
            chk("b_gnt", b_gnt, egb);
            chk("a_rvalid", a_rvalid, e.va);
            chk("b_rvalid", b_rvalid, e.vb);
            chk("a_err", a_err, e.va & e.err);
            chk("b_err", b_err, e.vb & e.err);
            chk("a_rdata", a_rdata, hold_a);
            chk("b_rdata", b_rdata, hold_b);
            chk("dmem_rden", dmem_rden, e.stb & !e.we);
            chk("dmem_wen", dmem_wen, e.stb & e.we);
            if (e.stb) begin
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_byte_sel", dmem_sel, e.sel);
                chk("dmem_sign", dmem_sign, e.sign);
                chk("dmem_data_in", dmem_din, e.wdata);
            end
            if (a_gnt || b_gnt) begin
                glog_cyc.push_back(cyc);
                glog_side.push_back(b_gnt);
            end
            if (dmem_wen) begin wen_cyc = cyc; wen_sel = dmem_sel; end
            if (dmem_rden && dmem_addr == 14'd1) saw_rd1 = 1;
            if (a_err) saw_aerr = 1;

            pipe0 = pipe1; pipe1 = pipe2; pipe2 = '0;
            if (ega || egb) begin
                c = egb ? cmd_t'({b_we, b_sel, b_sign, b_addr, b_wdata})
                        : cmd_t'({a_we, a_sel, a_sign, a_addr, a_wdata});
                if (egb) starve = 0;
                else if (b_req && starve < LIMIT) starve++;
                if (misal(c)) begin
                    pipe0.va = ega; pipe0.vb = egb; pipe0.err = 1'b1;
                    cool = 1;
                end else begin
                    pipe0.stb = 1'b1; pipe0.we = c.we; pipe0.addr = c.addr;
                    pipe0.sel = c.sel; pipe0.sign = c.sign; pipe0.wdata = c.wdata;
                    pipe1.va = ega; pipe1.vb = egb; pipe1.rd = !c.we;
                    pipe1.data = c.we ? 32'd0 : fmt(shadow[c.addr[13:2]], c.addr, c.sel, c.sign);
                    if (c.we) shadow_wr(c.addr, c.sel, c.wdata);
                    cool = 2;
                end
            end else if (cool > 0) begin
                cool--;
            end
            if (a_gnt && qa.size() > 0) void'(qa.pop_front());
            if (b_gnt && qb.size() > 0) void'(qb.pop_front());
        end
    end

    // Requesters present the head of their queue and hold it until granted.
    initial begin
        a_req = 0; a_we = 0; a_sel = 0; a_sign = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_sel = 0; b_sign = 0; b_addr = 0; b_wdata = 0;
        forever begin
            @(posedge clk); #1;
            if (qa.size() > 0) begin a_req = 1; {a_we, a_sel, a_sign, a_addr, a_wdata} = qa[0]; end
            else a_req = 0;
            if (qb.size() > 0) begin b_req = 1; {b_we, b_sel, b_sign, b_addr, b_wdata} = qb[0]; end
            else b_req = 0;
        end
    end

    task automatic drain(string name);
        int n;
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || cool != 0 || pipe0 != '0 || pipe1 != '0) && n < 80) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, (n >= 80), 0);
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic chk_zero(string p);
        chk({p, "_a_gnt"}, a_gnt, 0);       chk({p, "_b_gnt"}, b_gnt, 0);
        chk({p, "_a_rvalid"}, a_rvalid, 0); chk({p, "_b_rvalid"}, b_rvalid, 0);
        chk({p, "_a_err"}, a_err, 0);       chk({p, "_b_err"}, b_err, 0);
        chk({p, "_a_rdata"}, a_rdata, 0);   chk({p, "_b_rdata"}, b_rdata, 0);
        chk({p, "_rden"}, dmem_rden, 0);    chk({p, "_wen"}, dmem_wen, 0);
        chk({p, "_sel"}, dmem_sel, 0);      chk({p, "_sign"}, dmem_sign, 0);
        chk({p, "_addr"}, dmem_addr, 0);    chk({p, "_din"}, dmem_din, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_side [13];
        int k;
        exp_side = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 4096; i++) shadow[i] = 32'd0;
        rst_n = 0;
        #2;
        chk_zero("reset");

        // Word write then word read at address 0; first grant right after reset release.
        qa.push_back(mk(1, 2'b10, 0, 14'd0, 32'hDEADBEEF));
        qa.push_back(mk(0, 2'b10, 0, 14'd0, 32'h0));
        @(posedge clk); #2;
        chk("gnt_during_reset", a_gnt, 0);
        rst_n = 1;
        drain("wr_rd");
        chk("wr_rd_grants", glog_side.size(), 2);
        if (glog_side.size() >= 2) begin
            chk("first_gnt_cycle", glog_cyc[0], 1);
            chk("wr_rd_spacing", glog_cyc[1] - glog_cyc[0], 3);
            chk("wen_cycle", wen_cyc, glog_cyc[0] + 1);
        end
        chk("wen_byte_sel", wen_sel, 2'b10);
        chk("a_rdata_deadbeef", a_rdata, 32'hDEADBEEF);

        // B signed byte read of a word written by A.
        qa.push_back(mk(1, 2'b10, 0, 14'd8, 32'hDEADBEEF));
        qb.push_back(mk(0, 2'b00, 1, 14'd8, 32'h0));
        drain("byte_rd");
        chk("b_rdata_sext", b_rdata, 32'hFFFFFFEF);
        chk("b_err_byte", b_err, 0);
        chk("a_rdata_after_wr", a_rdata, 32'hDEADBEEF);

        // Sub-word writes and reads in word 4.
        qa.push_back(mk(1, 2'b01, 0, 14'h12, 32'h1234ABCD));
        qa.push_back(mk(1, 2'b00, 0, 14'h11, 32'h00000080));
        qa.push_back(mk(0, 2'b00, 1, 14'h11, 32'h0));
        qb.push_back(mk(0, 2'b01, 1, 14'h12, 32'h0));
        qb.push_back(mk(0, 2'b00, 0, 14'h11, 32'h0));
        drain("subword");
        chk("a_rdata_sbyte", a_rdata, 32'hFFFFFF80);
        chk("b_rdata_ubyte", b_rdata, 32'h00000080);

        // Both held high: A,A,A,A,B pattern, three cycles between grants.
        glog_cyc.delete(); glog_side.delete();
        for (int i = 0; i < 10; i++) qa.push_back(mk(0, 2'b10, 0, 14'(4 * i), 32'h0));
        qb.push_back(mk(0, 2'b10, 0, 14'd8, 32'h0));
        qb.push_back(mk(0, 2'b10, 0, 14'd0, 32'h0));
        qb.push_back(mk(0, 2'b10, 0, 14'd8, 32'h0));
        drain("starve");
        chk("starve_grants", glog_side.size(), 13);
        for (int i = 0; i < 13 && i < glog_side.size(); i++) begin
            chk($sformatf("starve_side%0d", i), glog_side[i], exp_side[i]);
            if (i > 0) chk($sformatf("starve_gap%0d", i), glog_cyc[i] - glog_cyc[i-1], 3);
        end
        chk("b_rdata_word8", b_rdata, 32'hDEADBEEF);

        // Misaligned word read at address 1.
        saw_rd1 = 0; saw_aerr = 0;
        qa.push_back(mk(0, 2'b10, 0, 14'd1, 32'h0));
        drain("misalign");
`ifdef DMEM_ARB_ALIGN_CHK_EN
        chk("misalign_err_seen", saw_aerr, 1);
        chk("misalign_no_rden", saw_rd1, 0);
`else
        chk("misalign_err_seen", saw_aerr, 0);
        chk("misalign_rden_addr1", saw_rd1, 1);
`endif

        // Reset pulse in the ISSUE cycle of a B read.
        qb.push_back(mk(0, 2'b10, 0, 14'd8, 32'h0));
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!b_gnt && k < 20);
        chk("b_gnt_before_reset", b_gnt, 1);
        @(posedge clk); #3;
        chk("rden_in_issue", dmem_rden, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk_zero("mid_reset");
        rst_n = 1;
        repeat (4) begin @(negedge clk); #1; end
        glog_cyc.delete(); glog_side.delete();
        qa.push_back(mk(0, 2'b10, 0, 14'd0, 32'h0));
        qb.push_back(mk(0, 2'b10, 0, 14'd8, 32'h0));
        drain("post_reset");
        chk("post_reset_grants", glog_side.size(), 2);
        if (glog_side.size() >= 2) begin
            chk("post_reset_first_A", glog_side[0], 0);
            chk("post_reset_second_B", glog_side[1], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
